// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencing for the 5-stage PPU: forwarding, load-use and HI/LO stalls, PC-select gating.
// Optional STALL_COUNTERS_EN adds saturating stall_cnt / md_stall_cnt performance counters.
module pipeline_hazard_controller #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_hilo_use,
    input  logic       id_b_instr,
    input  logic       id_ta_instr,
    input  logic       id_branch_taken,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_rf_en,
    input  logic       mem_rf_en,
    input  logic       wb_rf_en,
    input  logic       ex_load_instr,
    input  logic       ex_md_start,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       pc_ld,
    output logic       if_id_ld,
    output logic       id_ex_bubble,
    output logic       pc_sel_target,
    output logic       md_busy,
    output logic       md_done
`ifdef STALL_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] md_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        MD_WAIT
    } state_t;

    state_t     state;
    logic [4:0] md_count;
    logic       lu_hz;
    logic       md_hz;
    logic       stall;

    function automatic logic [1:0] fwd_of(
        input logic [4:0] r,
        input logic [4:0] e,
        input logic [4:0] m,
        input logic [4:0] w,
        input logic       ee,
        input logic       me,
        input logic       we
    );
        if (r == 5'd0) return 2'b00;
        if (ee && e == r) return 2'b01;
        if (me && m == r) return 2'b10;
        if (we && w == r) return 2'b11;
        return 2'b00;
    endfunction

    assign md_done = md_busy && (md_count == 5'd0);

    assign lu_hz = ex_load_instr && ex_rf_en && (ex_rd != 5'd0) &&
                   ((id_use_rs && id_rs == ex_rd) ||
                    (id_use_rt && id_rt == ex_rd));

    assign md_hz = id_hilo_use && md_busy;

    // The cycle after a load stall never stalls: EX holds a bubble then.
    assign stall = reset || (state == MD_WAIT) ||
                   ((state == RUN) && (md_hz || lu_hz));

    assign pc_ld         = ~stall;
    assign if_id_ld      = ~stall;
    assign id_ex_bubble  = stall;
    assign pc_sel_target = (id_ta_instr || (id_b_instr && id_branch_taken))
                           && ~stall;

    assign fwd_a_sel = reset ? 2'b00 :
        fwd_of(id_rs, ex_rd, mem_rd, wb_rd, ex_rf_en, mem_rf_en, wb_rf_en);
    assign fwd_b_sel = reset ? 2'b00 :
        fwd_of(id_rt, ex_rd, mem_rd, wb_rd, ex_rf_en, mem_rf_en, wb_rf_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (md_hz)
                        state <= md_done ? RUN : MD_WAIT;
                    else if (lu_hz)
                        state <= LOAD_STALL;
                end
                LOAD_STALL: state <= RUN;
                MD_WAIT: begin
                    if (md_done)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // A start while busy is dropped; HI/LO serves one operation at a time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_busy  <= 1'b0;
            md_count <= 5'd0;
        end else if (md_busy) begin
            if (md_count == 5'd0)
                md_busy <= 1'b0;
            else
                md_count <= md_count - 5'd1;
        end else if (ex_md_start) begin
            md_busy  <= 1'b1;
            md_count <= 5'(MD_LATENCY - 1);
        end
    end

`ifdef STALL_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (state == MD_WAIT && md_stall_cnt != '1)
                md_stall_cnt <= md_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
